// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with arbitrary depth, almost-full/empty thresholds,
// an occupancy count and either a registered or a first-word-fall-through read port.
module fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FIFO_WIDTH-1:0]           data_in,
    input  logic                            wr_en,
    input  logic                            rd_en,
    output logic [FIFO_WIDTH-1:0]           data_out,
    output logic                            wr_ack,
    output logic                            overflow,
    output logic                            underflow,
    output logic                            full,
    output logic                            empty,
    output logic                            almostfull,
    output logic                            almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

    logic [FIFO_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wa;
    logic                  w_ra;
    logic [CW-1:0]         w_count_next;

    // Pointers wrap explicitly at FIFO_DEPTH-1 so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        if (p == PTR_LAST) begin
            ptr_next = {AW{1'b0}};
        end else begin
            ptr_next = p + AW'(1);
        end
    endfunction

    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == {CW{1'b0}});
    assign w_wa        = wr_en && !w_full;
    assign w_ra        = rd_en && !w_empty;

    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= CNT_AF) && !w_full;
    assign almostempty = (r_count <= CNT_AE) && !w_empty;
    assign count       = r_count;
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    // Occupancy: a simultaneous accepted read and write leaves it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_wa, w_ra})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointer, occupancy and status-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wa) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_ra) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            r_count     <= w_count_next;
            r_wr_ack    <= w_wa;
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

    // Storage array is deliberately unreset.
    always_ff @(posedge clk) begin
        if (!rst && w_wa) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out = w_empty ? {FIFO_WIDTH{1'b0}} : r_mem[r_rd_ptr];
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] r_dout;

            // Registered read port holds its value across idle and rejected reads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout <= {FIFO_WIDTH{1'b0}};
                end else if (w_ra) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end

            assign data_out = r_dout;
        end
    endgenerate

    fifo_param_chk #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .full        (w_full),
        .empty       (w_empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .count       (r_count)
    );
endmodule

// Structural invariants of the occupancy decode.
module fifo_param_chk #(
    parameter int FIFO_DEPTH = 8
) (
    input logic                            clk,
    input logic                            rst,
    input logic                            full,
    input logic                            empty,
    input logic                            almostfull,
    input logic                            almostempty,
    input logic [$clog2(FIFO_DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    a_count_max: assert property (@(posedge clk) disable iff (rst) count <= CW'(FIFO_DEPTH));
    a_af_excl:   assert property (@(posedge clk) disable iff (rst) !(full && almostfull));
    a_ae_excl:   assert property (@(posedge clk) disable iff (rst) !(empty && almostempty));
    a_fe_excl:   assert property (@(posedge clk) disable iff (rst) !(full && empty));
endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: standard, FWFT and depth-5 instances.
`timescale 1ns/1ps
module tb_fifo_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Standard-mode instance, depth 8.
    logic        s_rst = 1'b1, s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [15:0] s_din = 16'h0000, s_dout;
    logic        s_wr_ack, s_ovf, s_udf, s_full, s_empty, s_af, s_ae;
    logic [3:0]  s_count;

    fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(s_rst), .data_in(s_din), .wr_en(s_wr_en), .rd_en(s_rd_en),
        .data_out(s_dout), .wr_ack(s_wr_ack), .overflow(s_ovf), .underflow(s_udf),
        .full(s_full), .empty(s_empty), .almostfull(s_af), .almostempty(s_ae), .count(s_count)
    );

    // FWFT instance, depth 8.
    logic        f_rst = 1'b1, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [15:0] f_din = 16'h0000, f_dout;
    logic        f_wr_ack, f_ovf, f_udf, f_full, f_empty, f_af, f_ae;
    logic [3:0]  f_count;

    fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(f_rst), .data_in(f_din), .wr_en(f_wr_en), .rd_en(f_rd_en),
        .data_out(f_dout), .wr_ack(f_wr_ack), .overflow(f_ovf), .underflow(f_udf),
        .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae), .count(f_count)
    );

    // Standard-mode instance, depth 5.
    logic        n_rst = 1'b1, n_wr_en = 1'b0, n_rd_en = 1'b0;
    logic [15:0] n_din = 16'h0000, n_dout;
    logic        n_wr_ack, n_ovf, n_udf, n_full, n_empty, n_af, n_ae;
    logic [2:0]  n_count;

    fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1'b0)) u_np (
        .clk(clk), .rst(n_rst), .data_in(n_din), .wr_en(n_wr_en), .rd_en(n_rd_en),
        .data_out(n_dout), .wr_ack(n_wr_ack), .overflow(n_ovf), .underflow(n_udf),
        .full(n_full), .empty(n_empty), .almostfull(n_af), .almostempty(n_ae), .count(n_count)
    );

    // Reference model for the depth-8 standard instance.
    logic [15:0] mq[$];
    logic [15:0] sb[$];
    logic [15:0] s_last = 16'h0000;
    bit          s_exp_ack, s_exp_ovf, s_exp_udf, s_exp_rd;

    // {count, full, empty, almostfull, almostempty} for depth 8, AF=7, AE=1.
    function automatic logic [7:0] s_flags(input int n);
        s_flags = {4'(n), n == 8, n == 0, n == 7, n == 1};
    endfunction

    // {count, full, empty, almostfull, almostempty} for depth 5, AF=4, AE=1.
    function automatic logic [6:0] n_flags(input int n);
        n_flags = {3'(n), n == 5, n == 0, n == 4, n == 1};
    endfunction

    task automatic std_drive(input bit w, input bit r, input logic [15:0] d);
        int n;
        n         = mq.size();
        s_exp_ack = w && (n < 8);
        s_exp_ovf = w && (n == 8);
        s_exp_udf = r && (n == 0);
        s_exp_rd  = r && (n > 0);
        if (s_exp_rd)  sb.push_back(mq.pop_front());
        if (s_exp_ack) mq.push_back(d);
        s_wr_en = w; s_rd_en = r; s_din = d;
        @(posedge clk); #1;
        s_wr_en = 1'b0; s_rd_en = 1'b0;
    endtask

    task automatic std_reset();
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        mq.delete(); sb.delete(); s_last = 16'h0000;
    endtask

    task automatic test_reset();
        s_rst = 1'b1; s_wr_en = 1'b1; s_rd_en = 1'b1; s_din = 16'hDEAD;
        @(posedge clk); #1;
        s_rst = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0;
        mq.delete(); sb.delete(); s_last = 16'h0000;
        n_total++;
        if ({s_count, s_full, s_empty, s_af, s_ae} !== 8'b0000_0100) begin
            n_bad++; $display("FAIL reset_flags: got %b want %b", {s_count, s_full, s_empty, s_af, s_ae}, 8'b0000_0100);
        end
        n_total++;
        if ({s_wr_ack, s_ovf, s_udf} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 000", {s_wr_ack, s_ovf, s_udf});
        end
        n_total++;
        if (s_dout !== 16'h0000) begin
            n_bad++; $display("FAIL reset_dout: got %h want 0000", s_dout);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 9; i++) begin
            std_drive(1'b1, 1'b0, 16'(i));
            n_total++;
            if ({s_count, s_full, s_empty, s_af, s_ae} !== s_flags(mq.size())) begin
                n_bad++; $display("FAIL fill_flags[%0d]: got %b want %b", i, {s_count, s_full, s_empty, s_af, s_ae}, s_flags(mq.size()));
            end
            n_total++;
            if ({s_wr_ack, s_ovf, s_udf} !== {s_exp_ack, s_exp_ovf, s_exp_udf}) begin
                n_bad++; $display("FAIL fill_pulses[%0d]: got %b want %b", i, {s_wr_ack, s_ovf, s_udf}, {s_exp_ack, s_exp_ovf, s_exp_udf});
            end
        end
        n_total++;
        if ({s_count, s_full, s_ovf, s_wr_ack} !== {4'd8, 1'b1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL fill_overflow: got %b want 1000110", {s_count, s_full, s_ovf, s_wr_ack});
        end
        std_drive(1'b0, 1'b0, 16'h0000);
        n_total++;
        if (s_ovf !== 1'b0) begin
            n_bad++; $display("FAIL overflow_pulse: got %b want 0", s_ovf);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 9; i++) begin
            std_drive(1'b0, 1'b1, 16'h0000);
            if (s_exp_rd) s_last = sb.pop_front();
            n_total++;
            if (s_dout !== s_last) begin
                n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, s_dout, s_last);
            end
            n_total++;
            if ({s_count, s_full, s_empty, s_af, s_ae, s_udf} !== {s_flags(mq.size()), s_exp_udf}) begin
                n_bad++; $display("FAIL drain_flags[%0d]: got %b want %b", i, {s_count, s_full, s_empty, s_af, s_ae, s_udf}, {s_flags(mq.size()), s_exp_udf});
            end
        end
        n_total++;
        if ({s_dout, s_udf, s_empty} !== {16'h0008, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL underflow_hold: got %h/%b/%b want 0008/1/1", s_dout, s_udf, s_empty);
        end
    endtask

    task automatic test_simultaneous();
        std_reset();
        for (int i = 0; i < 4; i++) std_drive(1'b1, 1'b0, 16'h0100 + 16'(i));
        for (int i = 0; i < 20; i++) begin
            std_drive(1'b1, 1'b1, 16'h0200 + 16'(i));
            if (s_exp_rd) s_last = sb.pop_front();
            n_total++;
            if ({s_count, s_ovf, s_udf, s_dout} !== {4'd4, 1'b0, 1'b0, s_last}) begin
                n_bad++; $display("FAIL simul_steady[%0d]: got cnt=%0d ovf=%b udf=%b dout=%h want cnt=4 ovf=0 udf=0 dout=%h", i, s_count, s_ovf, s_udf, s_dout, s_last);
            end
        end
        for (int i = 0; i < 4; i++) std_drive(1'b1, 1'b0, 16'h0300 + 16'(i));
        n_total++;
        if (s_full !== 1'b1) begin
            n_bad++; $display("FAIL simul_full: got %b want 1", s_full);
        end
        std_drive(1'b1, 1'b1, 16'hFFFF);
        s_last = sb.pop_front();
        n_total++;
        if ({s_count, s_ovf, s_wr_ack, s_dout} !== {4'd7, 1'b1, 1'b0, s_last}) begin
            n_bad++; $display("FAIL simul_full_both: got cnt=%0d ovf=%b ack=%b dout=%h want cnt=7 ovf=1 ack=0 dout=%h", s_count, s_ovf, s_wr_ack, s_dout, s_last);
        end
        for (int i = 0; i < 7; i++) begin
            std_drive(1'b0, 1'b1, 16'h0000);
            s_last = sb.pop_front();
            n_total++;
            if (s_dout !== s_last) begin
                n_bad++; $display("FAIL simul_drain[%0d]: got %h want %h", i, s_dout, s_last);
            end
        end
        std_drive(1'b1, 1'b1, 16'h0777);
        n_total++;
        if ({s_count, s_udf, s_wr_ack, s_dout} !== {4'd1, 1'b1, 1'b1, s_last}) begin
            n_bad++; $display("FAIL simul_empty_both: got cnt=%0d udf=%b ack=%b dout=%h want cnt=1 udf=1 ack=1 dout=%h", s_count, s_udf, s_wr_ack, s_dout, s_last);
        end
        std_drive(1'b0, 1'b1, 16'h0000);
        s_last = sb.pop_front();
        n_total++;
        if (s_dout !== 16'h0777) begin
            n_bad++; $display("FAIL simul_empty_word: got %h want 0777", s_dout);
        end
    endtask

    task automatic test_reset_mid();
        std_reset();
        for (int i = 0; i < 6; i++) std_drive(1'b1, 1'b0, 16'h0400 + 16'(i));
        n_total++;
        if (s_count !== 4'd6) begin
            n_bad++; $display("FAIL mid_precount: got %0d want 6", s_count);
        end
        s_rst = 1'b1; s_wr_en = 1'b1; s_din = 16'h0BAD;
        @(posedge clk); #1;
        s_rst = 1'b0; s_wr_en = 1'b0;
        mq.delete(); sb.delete(); s_last = 16'h0000;
        n_total++;
        if ({s_count, s_empty, s_wr_ack, s_dout} !== {4'd0, 1'b1, 1'b0, 16'h0000}) begin
            n_bad++; $display("FAIL mid_reset: got cnt=%0d empty=%b ack=%b dout=%h want 0/1/0/0000", s_count, s_empty, s_wr_ack, s_dout);
        end
        std_drive(1'b1, 1'b0, 16'hBEEF);
        std_drive(1'b0, 1'b1, 16'h0000);
        s_last = sb.pop_front();
        n_total++;
        if ({s_dout, s_empty} !== {16'hBEEF, 1'b1}) begin
            n_bad++; $display("FAIL mid_after: got %h/%b want beef/1", s_dout, s_empty);
        end
    endtask

    task automatic test_fwft();
        logic [15:0] fq[$];
        logic [15:0] vals[3] = '{16'hA5A5, 16'h1111, 16'h2222};
        logic [15:0] exp_d;
        f_rst = 1'b1;
        @(posedge clk); #1;
        f_rst = 1'b0;
        n_total++;
        if ({f_dout, f_empty} !== {16'h0000, 1'b1}) begin
            n_bad++; $display("FAIL fwft_reset: got %h/%b want 0000/1", f_dout, f_empty);
        end
        // write, pop, write, write, pop, pop
        for (int i = 0; i < 6; i++) begin
            f_wr_en = (i == 0) || (i == 2) || (i == 3);
            f_rd_en = (i == 1) || (i == 4) || (i == 5);
            f_din   = vals[(i == 0) ? 0 : i - 1];
            if (f_rd_en && fq.size() > 0) void'(fq.pop_front());
            if (f_wr_en) fq.push_back(f_din);
            @(posedge clk); #1;
            f_wr_en = 1'b0; f_rd_en = 1'b0;
            exp_d = (fq.size() > 0) ? fq[0] : 16'h0000;
            n_total++;
            if ({f_dout, f_empty, f_count} !== {exp_d, fq.size() == 0, 4'(fq.size())}) begin
                n_bad++; $display("FAIL fwft_step[%0d]: got dout=%h empty=%b cnt=%0d want dout=%h cnt=%0d", i, f_dout, f_empty, f_count, exp_d, fq.size());
            end
        end
    endtask

    task automatic test_nonpow2();
        logic [15:0] nq[$];
        logic [15:0] nsb[$];
        logic [15:0] n_last = 16'h0000;
        bit          w, r, e_ack, e_ovf, e_udf, e_rd;
        n_rst = 1'b1;
        @(posedge clk); #1;
        n_rst = 1'b0;
        for (int i = 0; i < 23; i++) begin
            w = (i < 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
            r = (i < 5) ? 1'b0 : ($urandom_range(0, 1) == 1);
            e_ack = w && (nq.size() < 5);
            e_ovf = w && (nq.size() == 5);
            e_udf = r && (nq.size() == 0);
            e_rd  = r && (nq.size() > 0);
            n_din = 16'($urandom);
            if (e_rd)  nsb.push_back(nq.pop_front());
            if (e_ack) nq.push_back(n_din);
            n_wr_en = w; n_rd_en = r;
            @(posedge clk); #1;
            n_wr_en = 1'b0; n_rd_en = 1'b0;
            if (e_rd) n_last = nsb.pop_front();
            n_total++;
            if ({n_count, n_full, n_empty, n_af, n_ae, n_wr_ack, n_ovf, n_udf, n_dout} !==
                {n_flags(nq.size()), e_ack, e_ovf, e_udf, n_last}) begin
                n_bad++; $display("FAIL np_step[%0d]: got %b/%b%b%b/%h want %b/%b%b%b/%h", i,
                    {n_count, n_full, n_empty, n_af, n_ae}, n_wr_ack, n_ovf, n_udf, n_dout,
                    n_flags(nq.size()), e_ack, e_ovf, e_udf, n_last);
            end
        end
        // drain everything left to confirm ordering across the wrap
        while (nq.size() > 0) begin
            n_last = nq.pop_front();
            n_rd_en = 1'b1;
            @(posedge clk); #1;
            n_rd_en = 1'b0;
            n_total++;
            if (n_dout !== n_last) begin
                n_bad++; $display("FAIL np_drain: got %h want %h", n_dout, n_last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_reset_mid();
        test_fwft();
        test_nonpow2();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
